// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register: FSM encoding and default counter width.
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_e;
  localparam int PIPE_CNT_W = 32;
endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the optional pipeline perf counters.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + WIDTH'(1);
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with 2-entry skid buffer, stall vector and flush.
// Optional perf counters (stall_cnt, flush_cnt) enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_STALL = 3,
  parameter int CNT_W   = PIPE_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [N_STALL-1:0] stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);
  pipe_state_e      state;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, adv;

  // Handshake flags come from registered state only, so in_ready never sees out_ready.
  assign in_ready  = (state != PS_SKID);
  assign out_valid = (state != PS_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign adv       = out_valid & out_ready & ~|stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        PS_EMPTY: if (accept) begin
          state  <= PS_FULL;
          main_q <= in_data;
        end
        PS_FULL: begin
          if (accept && adv) main_q <= in_data;
          else if (accept) begin
            state  <= PS_SKID;
            skid_q <= in_data;
          end else if (adv) state <= PS_EMPTY;
        end
        PS_SKID: if (adv) begin
          state  <= PS_FULL;
          main_q <= skid_q;
        end
        default: state <= PS_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~adv & ~flush),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & (state != PS_EMPTY)),
    .clr   (1'b0),
    .cnt   (flush_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus a random valid/ready/stall/flush phase.
module tb_pipe_stage_reg;
  localparam int WIDTH = 32;
  localparam int N_STALL = 3;
  localparam int CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [N_STALL-1:0] stall;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;
  logic [CNT_W-1:0]   base;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  pipe_stage_reg #(.WIDTH(WIDTH), .N_STALL(N_STALL), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; stall = '0; out_ready = 1'b1;
    step(3);
  endtask

  // Push side: record what the DUT accepted on this edge (inputs still hold last cycle's values).
  always @(posedge clk)
    if (rst_n && in_valid && in_ready && !flush) q.push_back(in_data);

  // Monitor: compare occupancy and head payload, then retire on advance and drop on flush.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(q[0]));
        if (out_ready && !(|stall)) void'(q.pop_front());
      end
      if (flush) q.delete();
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    step(2);
    rst_n = 1'b1;
    idle();

    // Streaming 1,2,3,4,5 at full rate
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      step();
    end
    idle();

    // Backpressure into the skid entry, then release
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_valid = 1'b0; step(3);
    check("bp_skid_in_ready", 64'(in_ready), 64'd0);
    check("bp_main_held", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    step(3);

    // Stall vector holds 0x55 for four cycles
    idle();
    in_valid = 1'b1; in_data = 32'h55; step();
    in_valid = 1'b0; stall = 3'b100;
`ifdef PIPE_STAGE_PERF_EN
    base = stall_cnt;
`endif
    step(4);
    check("stall_hold_data", 64'(out_data), 64'h55);
    check("stall_hold_valid", 64'(out_valid), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt_delta", 64'(stall_cnt - base), 64'd4);
`endif
    stall = '0; step();
    check("stall_release", 64'(out_valid), 64'd0);

    // Flush while SKID with 0x77 offered
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h61; step();
    in_data = 32'h62; step();
    check("flush_pre_skid", 64'(in_ready), 64'd0);
    in_data = 32'h77; flush = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
    base = flush_cnt;
`endif
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    check("flush_cnt_delta", 64'(flush_cnt - base), 64'd1);
`endif
    step(2);

    // Flush and stall together: flush wins
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h99; step();
    in_valid = 1'b0; flush = 1'b1; stall = 3'b010; step();
    flush = 1'b0; stall = '0;
    check("flush_stall_valid", 64'(out_valid), 64'd0);
    check("flush_stall_data", 64'(out_data), 64'd0);

    // Random traffic against the scoreboard
    idle();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      stall     = (($urandom % 4) == 0) ? N_STALL'($urandom_range(1, 7)) : '0;
      flush     = ($urandom % 50) == 0;
      step();
    end
    idle();
    check("drain_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset while in SKID
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC1; step();
    in_data = 32'hC2; step();
    check("pre_reset_skid", 64'(in_ready), 64'd0);
    in_data = 32'hCC;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    step(2);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle();
    check("post_reset_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
